// File: rtl/grey_histogram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grey_histogram: 256-bin grey-level histogram with clear / accumulate / readout
// Rev 1.0
// ---------------------------------------------------------------------------
module grey_histogram #(
  parameter int unsigned PIXELS_PER_FRAME = 262144,
  parameter int unsigned CNT_W            = 19
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  input  logic             i_grey_data_valid,
  input  logic [7:0]       i_grey_data,
  output logic             o_grey_ready,
  output logic             o_hist_valid,
  output logic [7:0]       o_hist_bin,
  output logic [CNT_W-1:0] o_hist_count,
  output logic             o_hist_last,
  input  logic             i_hist_ready,
  output logic             o_busy
);

  localparam int unsigned          c_pix_w    = $clog2(PIXELS_PER_FRAME + 1);
  localparam logic [c_pix_w-1:0]   c_pix_last = c_pix_w'(PIXELS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]     c_cnt_max  = '1;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [7:0]         clr_idx_q, clr_idx_d;
  logic [c_pix_w-1:0] pix_cnt_q, pix_cnt_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;
  // increment stage: bin whose RAM read was issued last cycle
  logic               s1_vld_q,  s1_vld_d;
  logic [7:0]         s1_bin_q,  s1_bin_d;
  // write committed last cycle, invisible to the read issued in that same cycle
  logic               fwd_vld_q, fwd_vld_d;
  logic [7:0]         fwd_bin_q, fwd_bin_d;
  logic [CNT_W-1:0]   fwd_val_q, fwd_val_d;
  // readout fetch pointer and the bin held in the RAM read register
  logic [8:0]         rd_ptr_q,  rd_ptr_d;
  logic               dv_q,      dv_d;
  logic [7:0]         db_q,      db_d;
  logic               hv_q,      hv_d;
  logic [7:0]         hbin_q,    hbin_d;
  logic [CNT_W-1:0]   hcnt_q,    hcnt_d;
  logic               hlast_q,   hlast_d;

  logic               ram_we;
  logic [7:0]         ram_waddr;
  logic [CNT_W-1:0]   ram_wdata;
  logic [7:0]         ram_raddr;
  logic [CNT_W-1:0]   ram_rdata;
  logic [CNT_W-1:0]   mem [256];

  logic               accept;
  logic [CNT_W-1:0]   old_val;
  logic [CNT_W-1:0]   inc_val;
  logic               hload;
  logic               xfer;

  assign accept  = (state_q == ST_ACCUM) && ready_q && i_grey_data_valid;
  assign old_val = (fwd_vld_q && (fwd_bin_q == s1_bin_q)) ? fwd_val_q : ram_rdata;
  assign inc_val = (old_val == c_cnt_max) ? old_val : old_val + 1'b1;
  assign hload   = (state_q == ST_READOUT) && dv_q && (!hv_q || i_hist_ready);
  assign xfer    = hv_q && i_hist_ready;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pix_cnt_d = pix_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    dv_d      = dv_q;
    db_d      = db_q;
    hv_d      = hv_q;
    hbin_d    = hbin_q;
    hcnt_d    = hcnt_q;
    hlast_d   = hlast_q;
    s1_vld_d  = accept;
    s1_bin_d  = i_grey_data;
    fwd_vld_d = s1_vld_q;
    fwd_bin_d = s1_bin_q;
    fwd_val_d = inc_val;
    ram_we    = s1_vld_q;
    ram_waddr = s1_bin_q;
    ram_wdata = inc_val;
    ram_raddr = i_grey_data;

    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q;
        ram_wdata = '0;
        clr_idx_d = clr_idx_q + 8'd1;
        if (clr_idx_q == 8'hFF) begin
          state_d   = ST_ACCUM;
          pix_cnt_d = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == c_pix_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // the final increment writes this cycle, so the first readout fetch sees it
        state_d  = ST_READOUT;
        rd_ptr_d = '0;
        dv_d     = 1'b0;
      end
      ST_READOUT: begin
        if (xfer) hv_d = 1'b0;
        if (hload) begin
          hv_d    = 1'b1;
          hbin_d  = db_q;
          hcnt_d  = ram_rdata;
          hlast_d = (db_q == 8'hFF);
        end
        if (dv_q && !hload) begin
          ram_raddr = db_q;
        end else if (!rd_ptr_q[8]) begin
          ram_raddr = rd_ptr_q[7:0];
          dv_d      = 1'b1;
          db_d      = rd_ptr_q[7:0];
          rd_ptr_d  = rd_ptr_q + 9'd1;
        end else begin
          dv_d = 1'b0;
        end
        if (xfer && hlast_q) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
          hv_d      = 1'b0;
          hlast_d   = 1'b0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    ready_d = (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_ACCUM);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      pix_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      s1_vld_q  <= 1'b0;
      s1_bin_q  <= '0;
      fwd_vld_q <= 1'b0;
      fwd_bin_q <= '0;
      fwd_val_q <= '0;
      rd_ptr_q  <= '0;
      dv_q      <= 1'b0;
      db_q      <= '0;
      hv_q      <= 1'b0;
      hbin_q    <= '0;
      hcnt_q    <= '0;
      hlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      pix_cnt_q <= pix_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      s1_vld_q  <= s1_vld_d;
      s1_bin_q  <= s1_bin_d;
      fwd_vld_q <= fwd_vld_d;
      fwd_bin_q <= fwd_bin_d;
      fwd_val_q <= fwd_val_d;
      rd_ptr_q  <= rd_ptr_d;
      dv_q      <= dv_d;
      db_q      <= db_d;
      hv_q      <= hv_d;
      hbin_q    <= hbin_d;
      hcnt_q    <= hcnt_d;
      hlast_q   <= hlast_d;
    end
  end

  // Histogram store: read-first single-clock RAM, contents only initialised by CLEAR
  always_ff @(posedge axi_clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  assign o_grey_ready = ready_q;
  assign o_busy       = busy_q;
  assign o_hist_valid = hv_q;
  assign o_hist_bin   = hbin_q;
  assign o_hist_count = hcnt_q;
  assign o_hist_last  = hlast_q;

endmodule
`default_nettype wire

// File: tb/tb_grey_histogram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_grey_histogram: three grey_histogram instances against a bin-count model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_grey_histogram;

  localparam int N_DUT = 3;

  logic axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  logic [N_DUT-1:0]       rst_n;
  logic [N_DUT-1:0]       gvalid;
  logic [N_DUT-1:0][7:0]  gdata;
  logic [N_DUT-1:0]       hready;
  wire  [N_DUT-1:0]       gready;
  wire  [N_DUT-1:0]       hvalid;
  wire  [N_DUT-1:0][7:0]  hbin;
  wire  [N_DUT-1:0][18:0] hcount;
  wire  [N_DUT-1:0]       hlast;
  wire  [N_DUT-1:0]       busy;
  wire  [3:0]             hcount_small;

  assign hcount[2] = {15'd0, hcount_small};

  grey_histogram #(.PIXELS_PER_FRAME(16), .CNT_W(19)) u_dut0 (
    .axi_clk(axi_clk), .axi_reset_n(rst_n[0]),
    .i_grey_data_valid(gvalid[0]), .i_grey_data(gdata[0]), .o_grey_ready(gready[0]),
    .o_hist_valid(hvalid[0]), .o_hist_bin(hbin[0]), .o_hist_count(hcount[0]),
    .o_hist_last(hlast[0]), .i_hist_ready(hready[0]), .o_busy(busy[0]));

  grey_histogram #(.PIXELS_PER_FRAME(256), .CNT_W(19)) u_dut1 (
    .axi_clk(axi_clk), .axi_reset_n(rst_n[1]),
    .i_grey_data_valid(gvalid[1]), .i_grey_data(gdata[1]), .o_grey_ready(gready[1]),
    .o_hist_valid(hvalid[1]), .o_hist_bin(hbin[1]), .o_hist_count(hcount[1]),
    .o_hist_last(hlast[1]), .i_hist_ready(hready[1]), .o_busy(busy[1]));

  grey_histogram #(.PIXELS_PER_FRAME(32), .CNT_W(4)) u_dut2 (
    .axi_clk(axi_clk), .axi_reset_n(rst_n[2]),
    .i_grey_data_valid(gvalid[2]), .i_grey_data(gdata[2]), .o_grey_ready(gready[2]),
    .o_hist_valid(hvalid[2]), .o_hist_bin(hbin[2]), .o_hist_count(hcount_small),
    .o_hist_last(hlast[2]), .i_hist_ready(hready[2]), .o_busy(busy[2]));

  int checks   = 0;
  int failures = 0;
  int exp_hist [256];

  function automatic int ppf(input int k);
    return (k == 0) ? 16 : (k == 1) ? 256 : 32;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 2) ? 15 : (1 << 19) - 1;
  endfunction

  // 0: constant 7, 1: ramp, 2: alternating 5/6, 3: random, 4: twenty 3s then others
  function automatic logic [7:0] pick(input int mode, input int i);
    logic [7:0] p;
    case (mode)
      0:       p = 8'd7;
      1:       p = 8'(i);
      2:       p = (i % 2 == 0) ? 8'd5 : 8'd6;
      4:       p = (i < 20) ? 8'd3 : 8'($urandom_range(4, 255));
      default: p = 8'($urandom);
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check($sformatf("%s_ready", tag), {31'd0, gready[k]}, 0);
    check($sformatf("%s_hvalid", tag), {31'd0, hvalid[k]}, 0);
    check($sformatf("%s_hlast", tag), {31'd0, hlast[k]}, 0);
    check($sformatf("%s_hbin", tag), {24'd0, hbin[k]}, 0);
    check($sformatf("%s_hcount", tag), {13'd0, hcount[k]}, 0);
    check($sformatf("%s_busy", tag), {31'd0, busy[k]}, 1);
  endtask

  // Called at a negedge with reset low; releases and times the CLEAR phase.
  task automatic release_and_time(input int k);
    int n = 0;
    logic early = 1'b0;
    rst_n[k] = 1'b1;
    while (!gready[k] && n < 400) begin
      @(negedge axi_clk);
      n++;
      if (!gready[k] && !busy[k]) early = 1'b1;
    end
    check($sformatf("dut%0d_clear_len", k), n, 256);
    check($sformatf("dut%0d_busy_in_clear", k), {31'd0, early}, 0);
    check($sformatf("dut%0d_busy_in_accum", k), {31'd0, busy[k]}, 0);
  endtask

  task automatic abort(input int k, input string tag);
    gvalid[k] = 1'b0;
    hready[k] = 1'b0;
    @(negedge axi_clk);
    #2 rst_n[k] = 1'b0;
    #1 check_reset_outputs(k, tag);
    @(negedge axi_clk);
    release_and_time(k);
  endtask

  task automatic send(input int k, input int mode, input bit gaps, input int n);
    int tmo = 0;
    for (int b = 0; b < 256; b++) exp_hist[b] = 0;
    // pixels offered before ACCUM must be ignored
    gvalid[k] = 1'b1;
    while (!gready[k] && tmo < 1000) begin
      gdata[k] = 8'($urandom);
      @(negedge axi_clk);
      tmo++;
    end
    check($sformatf("dut%0d_accum_wait", k), {31'd0, gready[k]}, 1);
    for (int i = 0; i < n; i++) begin
      logic [7:0] p;
      p = pick(mode, i);
      if (gaps && $urandom_range(0, 3) == 0) begin
        gvalid[k] = 1'b0;
        @(negedge axi_clk);
      end
      gvalid[k] = 1'b1;
      gdata[k]  = p;
      tmo = 0;
      while (!gready[k] && tmo < 100) begin
        @(negedge axi_clk);
        tmo++;
      end
      @(negedge axi_clk);
      if (exp_hist[p] < cnt_max(k)) exp_hist[p]++;
    end
    gvalid[k] = 1'b0;
    if (n == ppf(k)) begin
      check($sformatf("dut%0d_ready_drop", k), {31'd0, gready[k]}, 0);
      check($sformatf("dut%0d_busy_drain", k), {31'd0, busy[k]}, 1);
    end
  endtask

  task automatic read(input int k, input bit stall, input int limit);
    int   beats = 0;
    int   tmo   = 0;
    int   idle  = 0;
    logic pv = 1'b0, prdy = 1'b0, pl = 1'b0, rdy;
    logic [7:0]  pb = '0;
    logic [18:0] pc = '0;
    hready[k] = 1'b0;
    while (!hvalid[k] && tmo < 2000) begin
      @(negedge axi_clk);
      tmo++;
    end
    check($sformatf("dut%0d_readout_start", k), {31'd0, hvalid[k]}, 1);
    check($sformatf("dut%0d_busy_readout", k), {31'd0, busy[k]}, 1);
    while (beats < limit && tmo < 6000) begin
      if (pv && !prdy)
        check($sformatf("dut%0d_stall_hold", k), {hvalid[k], hlast[k], hbin[k], 3'd0, hcount[k]},
              {1'b1, pl, pb, 3'd0, pc});
      if (!hvalid[k]) idle++;
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hready[k] = rdy;
      if (hvalid[k] && rdy) begin
        check($sformatf("dut%0d_beat%0d_bin", k, beats), {24'd0, hbin[k]}, beats);
        check($sformatf("dut%0d_beat%0d_count", k, beats), {13'd0, hcount[k]}, exp_hist[beats]);
        check($sformatf("dut%0d_beat%0d_last", k, beats), {31'd0, hlast[k]}, (beats == 255) ? 1 : 0);
        beats++;
      end
      pv = hvalid[k]; prdy = rdy; pl = hlast[k]; pb = hbin[k]; pc = hcount[k];
      @(negedge axi_clk);
      tmo++;
    end
    hready[k] = 1'b0;
    if (limit == 256) begin
      check($sformatf("dut%0d_beats", k), beats, 256);
      check($sformatf("dut%0d_valid_after_last", k), {31'd0, hvalid[k]}, 0);
      if (!stall) check($sformatf("dut%0d_gaps", k), idle, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = '0;
    gvalid = '0;
    gdata  = '0;
    hready = '0;
    repeat (3) @(negedge axi_clk);
    for (int k = 0; k < N_DUT; k++) check_reset_outputs(k, $sformatf("dut%0d_por", k));
    for (int k = 0; k < N_DUT; k++) release_and_time(k);

    send(0, 0, 1'b0, 16);  read(0, 1'b0, 256);
    send(0, 3, 1'b1, 16);  read(0, 1'b1, 256);

    send(1, 1, 1'b0, 256); read(1, 1'b0, 256);
    send(1, 2, 1'b0, 256); read(1, 1'b1, 256);
    send(1, 3, 1'b1, 256); read(1, 1'b1, 256);

    send(2, 4, 1'b0, 32);  read(2, 1'b1, 256);

    send(1, 0, 1'b0, 100); abort(1, "dut1_abort_accum");
    send(1, 3, 1'b1, 256); read(1, 1'b1, 256);

    send(1, 3, 1'b0, 256); read(1, 1'b1, 50);
    abort(1, "dut1_abort_readout");
    send(1, 2, 1'b1, 256); read(1, 1'b1, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
